// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader slice.
//   state_t      : loader FSM state, 3-bit encoding
//   INSTR_W_DEF  : default instruction word width
//   DEPTH_DEF    : default program buffer depth (power of two)
package loader_pkg;

  localparam int unsigned INSTR_W_DEF = 23;
  localparam int unsigned DEPTH_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Host-load and processor-issue signals of the program loader.
//   load_valid/load_data/load_ready : host appends program words
//   start/program_out/proc_done     : instruction issue to processor and completion
// master: host/processor side; slave: program_loader.
interface program_loader_if
  import loader_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF
);

  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic               load_ready;
  logic               start;
  logic [INSTR_W-1:0] program_out;
  logic               proc_done;

  modport master (
    output load_valid, load_data, proc_done,
    input  load_ready, start, program_out
  );

  modport slave (
    input  load_valid, load_data, proc_done,
    output load_ready, start, program_out
  );

endinterface

// File: rtl/program_loader_buffer.sv
// prog_buffer: DEPTH x INSTR_W program store.
//   clk             : write clock
//   wr_en/wr_addr/wr_data : single synchronous write port
//   rd_addr/rd_data : combinational read port
// Contents are not reset.
module prog_buffer
  import loader_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [INSTR_W-1:0]       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [INSTR_W-1:0]       rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/program_loader.sv
// program_loader: buffers a program from a host and issues it word by word
// to a processor, waiting for proc_done after each start strobe.
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   host (slave)     : load_valid/load_data/load_ready, start/program_out/proc_done
//   prog_clear       : empty the buffer (IDLE/DONE/ERR only)
//   run              : execute the buffered program from pc=0
//   busy / finished  : in ISSUE or WAIT / in DONE
//   pc / count       : current instruction index / number of buffered words
// Optional macro PROGRAM_LOADER_TIMEOUT_EN: WAIT watchdog of TIMEOUT_CYCLES
// cycles leading to ERR; without it WAIT lasts indefinitely.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned INSTR_W        = INSTR_W_DEF,
  parameter int unsigned DEPTH          = DEPTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  program_loader_if.slave          host,
  input  logic                     prog_clear,
  input  logic                     run,
  output logic                     busy,
  output logic                     finished,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t          state, state_n;
  logic [AW:0]     count_n;
  logic [AW-1:0]   pc_n;
  logic            load_hs;
  logic            wr_en;
  logic            at_last;
  logic            timeout;
  logic [INSTR_W-1:0] rd_data;

  prog_buffer #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count[AW-1:0]),
    .wr_data (host.load_data),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

`ifdef PROGRAM_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;

  // Counts consecutive WAIT cycles without proc_done; the first WAIT cycle reads 0.
  always_ff @(posedge clk) begin
    if (reset || state != WAIT || host.proc_done) tcnt <= '0;
    else                                         tcnt <= tcnt + 1'b1;
  end

  assign timeout = (tcnt == TLAST);
`else
  assign timeout = 1'b0;
`endif

  assign host.load_ready = (state == IDLE || state == DONE) && (count != FULL);
  assign load_hs         = host.load_valid && host.load_ready;
  assign at_last         = ({1'b0, pc} == count - {{AW{1'b0}}, 1'b1});

  assign busy     = (state == ISSUE) || (state == WAIT);
  assign finished = (state == DONE);
  assign host.start = (state == ISSUE);
  // pc and buffer are frozen while busy, so the read port holds program_out steady.
  assign host.program_out = busy ? rd_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pc    <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    count_n = count;
    pc_n    = pc;
    wr_en   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (prog_clear) begin
          state_n = IDLE;
          count_n = '0;
          pc_n    = '0;
        end else if (load_hs) begin
          // An append always drops back to IDLE so finished clears; a
          // concurrent run is ignored.
          wr_en   = 1'b1;
          count_n = count + 1'b1;
          state_n = IDLE;
        end else if (run && count != '0) begin
          pc_n    = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (host.proc_done) begin
          if (at_last) begin
            state_n = DONE;
          end else begin
            pc_n    = pc + 1'b1;
            state_n = ISSUE;
          end
        end else if (timeout) begin
          state_n = ERR;
        end
      end
      ERR: begin
        if (prog_clear) begin
          state_n = IDLE;
          count_n = '0;
          pc_n    = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        prog_clear;
  logic        run;
  logic        busy;
  logic        finished;
  logic [3:0]  pc;
  logic [4:0]  count;

  int n_assert = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int s0;

  program_loader_if #(.INSTR_W(23)) bus ();

  program_loader #(
    .INSTR_W        (23),
    .DEPTH          (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (bus.slave),
    .prog_clear (prog_clear),
    .run        (run),
    .busy       (busy),
    .finished   (finished),
    .pc         (pc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.start === 1'b1) n_starts++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [22:0] d);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  // Called in ISSUE; proc_done is sampled on the second edge after the start cycle.
  task automatic run_instr(input logic [22:0] exp, input logic [3:0] p, input string tag);
    check({tag, "_start"}, 32'(bus.start), 32'd1);
    check({tag, "_data"}, 32'(bus.program_out), 32'(exp));
    check({tag, "_pc"}, 32'(pc), 32'(p));
    step();
    check({tag, "_start_low"}, 32'(bus.start), 32'd0);
    check({tag, "_hold"}, 32'(bus.program_out), 32'(exp));
    step();
    bus.proc_done = 1'b1;
    step();
    bus.proc_done = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    prog_clear     = 1'b0;
    run            = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.proc_done  = 1'b0;
    step();
    step();
    check("rst_ready", 32'(bus.load_ready), 32'd1);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_finished", 32'(finished), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pout", 32'(bus.program_out), 32'd0);
    reset = 1'b0;

    // run on an empty buffer
    start_run();
    check("empty_run_busy", 32'(busy), 32'd0);
    check("empty_run_start", 32'(bus.start), 32'd0);
    step();
    check("empty_run_busy2", 32'(busy), 32'd0);
    check("empty_run_nstart", 32'(n_starts), 32'd0);

    // three-word program
    load_word(23'h000001);
    load_word(23'h000002);
    load_word(23'h000003);
    check("p3_count", 32'(count), 32'd3);
    start_run();
    run_instr(23'h000001, 4'd0, "p3_i0");
    run_instr(23'h000002, 4'd1, "p3_i1");
    run_instr(23'h000003, 4'd2, "p3_i2");
    check("p3_finished", 32'(finished), 32'd1);
    check("p3_pc", 32'(pc), 32'd2);
    check("p3_busy", 32'(busy), 32'd0);
    check("p3_nstart", 32'(n_starts), 32'd3);

    // load and run together in DONE: append wins
    bus.load_valid = 1'b1;
    bus.load_data  = 23'h000004;
    run            = 1'b1;
    step();
    bus.load_valid = 1'b0;
    run            = 1'b0;
    check("ldrun_count", 32'(count), 32'd4);
    check("ldrun_finished", 32'(finished), 32'd0);
    check("ldrun_busy", 32'(busy), 32'd0);
    check("ldrun_start", 32'(bus.start), 32'd0);
    start_run();
    for (int i = 0; i < 4; i++) run_instr(23'(i + 1), 4'(i), "rerun");
    check("rerun_finished", 32'(finished), 32'd1);
    check("rerun_pc", 32'(pc), 32'd3);
    check("rerun_nstart", 32'(n_starts), 32'd7);

    // full buffer
    prog_clear = 1'b1;
    step();
    prog_clear = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_pc", 32'(pc), 32'd0);
    check("clr_finished", 32'(finished), 32'd0);
    for (int i = 0; i < 16; i++) load_word(23'(32'h100 + i));
    check("full_count", 32'(count), 32'd16);
    check("full_ready", 32'(bus.load_ready), 32'd0);
    load_word(23'h7fffff);
    check("full_drop_count", 32'(count), 32'd16);
    start_run();
    for (int i = 0; i < 16; i++) run_instr(23'(32'h100 + i), 4'(i), "full");
    check("full_finished", 32'(finished), 32'd1);
    check("full_pc", 32'(pc), 32'd15);
    check("full_nstart", 32'(n_starts), 32'd23);

    // reset abort in WAIT of the second of four instructions
    prog_clear = 1'b1;
    step();
    prog_clear = 1'b0;
    for (int i = 0; i < 4; i++) load_word(23'(32'h10 + i));
    start_run();
    run_instr(23'h000010, 4'd0, "ab_i0");
    check("ab_i1_start", 32'(bus.start), 32'd1);
    check("ab_i1_data", 32'(bus.program_out), 32'h11);
    step();
    bus.load_valid = 1'b1;
    bus.load_data  = 23'h000055;
    check("busy_ready", 32'(bus.load_ready), 32'd0);
    step();
    bus.load_valid = 1'b0;
    check("busy_drop_count", 32'(count), 32'd4);
    check("ab_in_wait", 32'(busy), 32'd1);
    reset         = 1'b1;
    bus.proc_done = 1'b1;
    step();
    reset         = 1'b0;
    bus.proc_done = 1'b0;
    s0 = n_starts;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_count", 32'(count), 32'd0);
    check("ab_pc", 32'(pc), 32'd0);
    check("ab_start", 32'(bus.start), 32'd0);
    check("ab_pout", 32'(bus.program_out), 32'd0);
    bus.proc_done = 1'b1;
    step();
    bus.proc_done = 1'b0;
    step();
    step();
    check("ab_nstart", 32'(n_starts), 32'(s0));
    check("ab_ready", 32'(bus.load_ready), 32'd1);

`ifdef PROGRAM_LOADER_TIMEOUT_EN
    load_word(23'h00002a);
    start_run();
    check("to_start", 32'(bus.start), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("to_wait_busy", 32'(busy), 32'd1);
    end
    step();
    check("to_err_busy", 32'(busy), 32'd0);
    check("to_err_finished", 32'(finished), 32'd0);
    check("to_err_start", 32'(bus.start), 32'd0);
    check("to_err_ready", 32'(bus.load_ready), 32'd0);
    start_run();
    check("to_err_run_busy", 32'(busy), 32'd0);
    check("to_err_run_ready", 32'(bus.load_ready), 32'd0);
    prog_clear = 1'b1;
    step();
    prog_clear = 1'b0;
    check("to_clr_ready", 32'(bus.load_ready), 32'd1);
    check("to_clr_count", 32'(count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
